// File: rtl/captura_jogada.sv
// Player input stage: synchronises and debounces four push buttons and latches one
// one-hot move per press/release cycle, flagging invalid presses and response timeout.
module captura_jogada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic       timeout,
    output logic       ocupado
);

    localparam int DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam bit            T_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA,
        FILTRO,
        REGISTRA,
        SOLTA,
        ESGOTADO
    } state_t;

    state_t          state;
    logic [3:0]      meta;
    logic [3:0]      b_s;
    logic [3:0]      cand;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt;
    logic            d_hit;
    logic            t_hit;

    function automatic logic [DW-1:0] inc_d(input logic [DW-1:0] v);
        return (v < D_MAX) ? v + DW'(1) : v;
    endfunction

    function automatic logic [TW-1:0] inc_t(input logic [TW-1:0] v);
        return (v < T_MAX) ? v + TW'(1) : v;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Two-flop synchroniser; every decision below looks only at b_s.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 4'd0;
            b_s  <= 4'd0;
        end else begin
            meta <= botoes;
            b_s  <= meta;
        end
    end

    assign d_hit = (dcnt == D_LAST);
    assign t_hit = T_EN && (tcnt == T_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= OCIOSO;
            jogada          <= 4'd0;
            jogada_feita    <= 1'b0;
            jogada_invalida <= 1'b0;
            timeout         <= 1'b0;
            ocupado         <= 1'b0;
            cand            <= 4'd0;
            dcnt            <= '0;
            tcnt            <= '0;
        end else begin
            jogada_feita    <= 1'b0;
            jogada_invalida <= 1'b0;
            timeout         <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (habilita) begin
                        ocupado <= 1'b1;
                        // A button already down while arming must be released first.
                        if (b_s == 4'd0) begin
                            state <= ESPERA;
                            tcnt  <= '0;
                        end else begin
                            state <= SOLTA;
                            dcnt  <= '0;
                        end
                    end
                end
                ESPERA: begin
                    tcnt <= inc_t(tcnt);
                    if (!habilita) begin
                        state   <= OCIOSO;
                        ocupado <= 1'b0;
                    end else if (t_hit) begin
                        state   <= ESGOTADO;
                        timeout <= 1'b1;
                    end else if (b_s != 4'd0) begin
                        state <= FILTRO;
                        cand  <= b_s;
                        dcnt  <= '0;
                    end
                end
                FILTRO: begin
                    tcnt <= inc_t(tcnt);
                    if (!habilita) begin
                        state   <= OCIOSO;
                        ocupado <= 1'b0;
                    end else if ((b_s == cand) && d_hit) begin
                        state <= REGISTRA;
                        if (is_onehot(cand)) begin
                            jogada       <= cand;
                            jogada_feita <= 1'b1;
                        end else begin
                            jogada_invalida <= 1'b1;
                        end
                    end else if (t_hit) begin
                        state   <= ESGOTADO;
                        timeout <= 1'b1;
                    end else if (b_s != cand) begin
                        // Bounce: the timeout budget keeps running.
                        state <= ESPERA;
                    end else begin
                        dcnt <= inc_d(dcnt);
                    end
                end
                REGISTRA: begin
                    state <= SOLTA;
                    dcnt  <= '0;
                end
                SOLTA: begin
                    if (b_s != 4'd0) begin
                        dcnt <= '0;
                    end else if (d_hit) begin
                        if (habilita) begin
                            state <= ESPERA;
                            tcnt  <= '0;
                        end else begin
                            state   <= OCIOSO;
                            ocupado <= 1'b0;
                        end
                    end else begin
                        dcnt <= inc_d(dcnt);
                    end
                end
                ESGOTADO: begin
                    state   <= OCIOSO;
                    ocupado <= 1'b0;
                end
                default: begin
                    state   <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
